viterbi_codec: RTL and testbench

- Rate-1/2, constraint-length-3 convolutional encoder (generators 7,5 octal) plus a matching 4-state hard-decision Viterbi decoder, in one block.
- The encoder drives the channel and the decoder consumes the (possibly corrupted) channel symbols. The two paths are independent inside the block; the channel and its register sit outside.
- The decoder uses add-compare-select (ACS) with normalised path metrics and register-exchange survivor paths of fixed depth.

---
 rtl/viterbi_pkg.sv | 16 +
 rtl/viterbi_acs.sv | 36 +++
 rtl/viterbi_codec.sv | 127 ++++++++++++
 tb/tb_viterbi_codec.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the (7,5) rate-1/2 K=3 codec.
package viterbi_pkg;
  localparam int         K          = 3;
  localparam int         NUM_STATES = 4;
  localparam logic [2:0] G0         = 3'b111;
  localparam logic [2:0] G1         = 3'b101;

  typedef logic [1:0] state_t;

  // Symbol emitted when input b is shifted into state s={s1,s0}; taps are {b,s1,s0}.
  function automatic logic [1:0] exp_sym(state_t s, logic b);
    logic [2:0] r;
    r = {b, s};
    return {^(r & G0), ^(r & G1)};
  endfunction
endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for all four trellis states with saturating, normalised metrics.
module viterbi_acs import viterbi_pkg::*; #(
  parameter int PM_W = 6
) (
  input  logic [NUM_STATES-1:0][PM_W-1:0] pm_i,
  input  logic [1:0]                      sym_i,
  output logic [NUM_STATES-1:0][PM_W-1:0] pm_o,
  output logic [NUM_STATES-1:0]           sel_o,
  output logic [PM_W-1:0]                 min_o
);
  logic [NUM_STATES-1:0][PM_W-1:0] c0, c1, raw;

  function automatic logic [1:0] hd(logic [1:0] a, logic [1:0] b);
    return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(logic [PM_W-1:0] a, logic [1:0] bm);
    logic [PM_W:0] s;
    s = {1'b0, a} + {1'b0, {(PM_W-2){1'b0}}, bm};
    return s[PM_W] ? '1 : s[PM_W-1:0];
  endfunction

  // Next state n={b,p} is reached from {p,0} or {p,1}; sel_o records the chosen s0.
  always_comb begin
    min_o = '1;
    for (int n = 0; n < NUM_STATES; n++) begin
      c0[n]    = sat_add(pm_i[{n[0], 1'b0}], hd(sym_i, exp_sym({n[0], 1'b0}, n[1])));
      c1[n]    = sat_add(pm_i[{n[0], 1'b1}], hd(sym_i, exp_sym({n[0], 1'b1}, n[1])));
      sel_o[n] = c1[n] < c0[n];
      raw[n]   = sel_o[n] ? c1[n] : c0[n];
      if (raw[n] < min_o) min_o = raw[n];
    end
    for (int n = 0; n < NUM_STATES; n++)
      pm_o[n] = raw[n] - min_o;
  end
endmodule

// File: rtl/viterbi_codec.sv
// (7,5) convolutional encoder plus 4-state hard-decision register-exchange Viterbi decoder.
// Define VITERBI_ERR_CNT_EN to add the dec_err_cnt_o channel-error counter.
module viterbi_codec import viterbi_pkg::*; #(
  parameter int TRACE_DEPTH = 16,
  parameter int PM_W        = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_enable_i,
  input  logic        enc_d_i,
  output logic        enc_valid_o,
  output logic [1:0]  enc_d_o,
  input  logic        dec_enable_i,
  input  logic [1:0]  dec_d_i,
  output logic        dec_valid_o,
  output logic        dec_d_o
`ifdef VITERBI_ERR_CNT_EN
  ,
  output logic [15:0] dec_err_cnt_o
`endif
);
  localparam int              CNT_W   = $clog2(TRACE_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_INIT = PM_W'(1 << (PM_W - 2));

  state_t     enc_state_q, enc_state_d;
  logic       enc_valid_q, enc_valid_d;
  logic [1:0] enc_sym_q, enc_sym_d;

  always_comb begin
    enc_state_d = enc_state_q;
    enc_sym_d   = enc_sym_q;
    enc_valid_d = enc_enable_i;
    if (enc_enable_i) begin
      enc_sym_d   = exp_sym(enc_state_q, enc_d_i);
      enc_state_d = {enc_d_i, enc_state_q[1]};
    end
  end

  logic [NUM_STATES-1:0][PM_W-1:0]        pm_q, pm_d, acs_pm;
  logic [NUM_STATES-1:0]                  acs_sel;
  logic [PM_W-1:0]                        acs_min;
  logic [NUM_STATES-1:0][TRACE_DEPTH-1:0] surv_q, surv_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic                                   dec_valid_q, dec_valid_d;
  logic                                   dec_bit_q, dec_bit_d;
  state_t                                 best;

  viterbi_acs #(.PM_W(PM_W)) u_acs (
    .pm_i  (pm_q),
    .sym_i (dec_d_i),
    .pm_o  (acs_pm),
    .sel_o (acs_sel),
    .min_o (acs_min)
  );

  // Strict compare keeps the lowest-index state on a metric tie.
  always_comb begin
    best = '0;
    for (int n = 1; n < NUM_STATES; n++)
      if (pm_q[n] < pm_q[best]) best = state_t'(n);
  end

  always_comb begin
    pm_d        = pm_q;
    surv_d      = surv_q;
    cnt_d       = cnt_q;
    dec_bit_d   = dec_bit_q;
    dec_valid_d = 1'b0;
    if (dec_enable_i) begin
      pm_d = acs_pm;
      for (int n = 0; n < NUM_STATES; n++)
        surv_d[n] = {surv_q[{n[0], acs_sel[n]}][TRACE_DEPTH-2:0], n[1]};
      dec_bit_d   = surv_q[best][TRACE_DEPTH-1];
      dec_valid_d = (cnt_q == CNT_W'(TRACE_DEPTH));
      if (cnt_q != CNT_W'(TRACE_DEPTH)) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enc_state_q <= '0;
      enc_valid_q <= 1'b0;
      enc_sym_q   <= '0;
      pm_q        <= {PM_INIT, PM_INIT, PM_INIT, {PM_W{1'b0}}};
      surv_q      <= '0;
      cnt_q       <= '0;
      dec_valid_q <= 1'b0;
      dec_bit_q   <= 1'b0;
    end else begin
      enc_state_q <= enc_state_d;
      enc_valid_q <= enc_valid_d;
      enc_sym_q   <= enc_sym_d;
      pm_q        <= pm_d;
      surv_q      <= surv_d;
      cnt_q       <= cnt_d;
      dec_valid_q <= dec_valid_d;
      dec_bit_q   <= dec_bit_d;
    end
  end

  assign enc_valid_o = enc_valid_q;
  assign enc_d_o     = enc_sym_q;
  assign dec_valid_o = dec_valid_q;
  assign dec_d_o     = dec_bit_q;

`ifdef VITERBI_ERR_CNT_EN
  // The amount removed by normalisation accumulates into the best path's Hamming cost.
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] err_sum;

  always_comb begin
    err_sum   = {1'b0, err_cnt_q} + 17'(acs_min);
    err_cnt_d = err_cnt_q;
    if (dec_enable_i) err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt_q <= '0;
    else      err_cnt_q <= err_cnt_d;
  end

  assign dec_err_cnt_o = err_cnt_q;
`else
  logic unused_min;
  assign unused_min = ^acs_min;
`endif
endmodule

// File: tb/tb_viterbi_codec.sv
// Bench for viterbi_codec: reference is the source bit stream delayed by the trace depth.
module tb_viterbi_codec;
  localparam int TD = 16;

  logic       clk, rst;
  logic       enc_enable_i, enc_d_i, enc_valid_o;
  logic [1:0] enc_d_o, dec_d_i;
  logic       dec_enable_i, dec_valid_o, dec_d_o;
`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] dec_err_cnt_o;
`endif

  viterbi_codec #(.TRACE_DEPTH(TD), .PM_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_enable_i (enc_enable_i),
    .enc_d_i      (enc_d_i),
    .enc_valid_o  (enc_valid_o),
    .enc_d_o      (enc_d_o),
    .dec_enable_i (dec_enable_i),
    .dec_d_i      (dec_d_i),
    .dec_valid_o  (dec_valid_o),
    .dec_d_o      (dec_d_o)
`ifdef VITERBI_ERR_CNT_EN
    ,
    .dec_err_cnt_o(dec_err_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0, errors = 0;
  bit         ref_bits[$];
  logic [1:0] chan_q[$];
  int         dec_n = 0, chan_idx = 0, valid_seen = 0, first_en = 0;
  bit         burst = 0, first_pending = 0;
  logic       exp_ev = 0, exp_dv = 0, exp_dd = 0, first_bit = 0;
  logic [1:0] exp_es = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th most recent input bit to the encoder (zero before the stream started).
  function automatic bit past(int k);
    return (ref_bits.size() >= k) ? ref_bits[ref_bits.size() - k] : 1'b0;
  endfunction

  task automatic tick();
    logic       c_rst, c_ee, c_ed, c_de;
    logic [2:0] win;
    c_rst = rst; c_ee = enc_enable_i; c_ed = enc_d_i; c_de = dec_enable_i;
    @(posedge clk);
    #1;
    if (!c_rst) begin
      ref_bits.delete(); chan_q.delete();
      dec_n = 0; chan_idx = 0;
      exp_ev = 0; exp_es = 0; exp_dv = 0; exp_dd = 0;
    end else begin
      exp_ev = c_ee;
      if (c_ee) begin
        win    = {c_ed, past(1), past(2)};
        exp_es = {^(win & 3'b111), ^(win & 3'b101)};
        ref_bits.push_back(c_ed);
      end
      exp_dv = 0;
      if (c_de) begin
        exp_dv = (dec_n >= TD);
        exp_dd = (dec_n >= TD) ? ref_bits[dec_n - TD] : 1'b0;
        dec_n++;
      end
    end
    chk("enc_valid", enc_valid_o, exp_ev);
    chk("enc_sym", enc_d_o, exp_es);
    chk("dec_valid", dec_valid_o, exp_dv);
    chk("dec_bit", dec_d_o, exp_dd);
    if (dec_valid_o) valid_seen++;
    if (first_pending && dec_valid_o) begin
      first_pending = 0; first_en = dec_n; first_bit = dec_d_o;
    end
    if (c_rst && enc_valid_o) begin
      chan_q.push_back(enc_d_o ^ ((burst && (chan_idx % 16 == 1)) ? 2'b11 : 2'b00));
      chan_idx++;
    end
  endtask

  task automatic drive(bit ee, bit ed, bit de);
    enc_enable_i = ee; enc_d_i = ed;
    if (de && chan_q.size() > 0) begin
      dec_enable_i = 1'b1; dec_d_i = chan_q.pop_front();
    end else begin
      dec_enable_i = 1'b0; dec_d_i = 2'($urandom);
    end
    tick();
  endtask

  task automatic do_reset(int n);
    rst = 1'b0; enc_enable_i = 0; enc_d_i = 0; dec_enable_i = 0; dec_d_i = 0;
    repeat (n) tick();
    rst = 1'b1;
  endtask

  task automatic run_stream(int nbits, int duty, bit brst, int abort_after);
    logic [15:0] lfsr;
    int          sent, cyc;
    bit          ee, de, b;
    lfsr = 16'hACE1; sent = 0; cyc = 0; burst = brst;
    while (sent < nbits || chan_q.size() > 0) begin
      if (abort_after >= 0 && dec_n > abort_after) break;
      if (cyc++ > 4000) begin
        checks++; errors++;
        $display("FAIL stream_timeout: sent %0d of %0d, queue %0d", sent, nbits, chan_q.size());
        break;
      end
      ee = (sent < nbits) && ($urandom_range(99) < duty);
      de = ($urandom_range(99) < duty);
      b  = lfsr[0];
      if (ee) begin
        lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        sent++;
      end
      drive(ee, b, de);
    end
    drive(0, 0, 0);
    drive(0, 0, 0);
  endtask

  logic [1:0] imp_exp [4];

  initial begin
    imp_exp = '{2'b11, 2'b10, 2'b11, 2'b00};
    rst = 1'b1; enc_enable_i = 0; enc_d_i = 0; dec_enable_i = 0; dec_d_i = 0;
    #2;
    do_reset(2);
    chk("rst_enc_valid", enc_valid_o, 0);
    chk("rst_enc_sym", enc_d_o, 0);
    chk("rst_dec_valid", dec_valid_o, 0);
    chk("rst_dec_bit", dec_d_o, 0);
`ifdef VITERBI_ERR_CNT_EN
    chk("rst_err_cnt", dec_err_cnt_o, 0);
`endif
    valid_seen = 0;
    repeat (40) drive(0, 0, 0);
    chk("idle_valid_cnt", valid_seen, 0);

    // Encoder impulse response is the generator pair itself.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 0), 1);
      chk("impulse_sym", enc_d_o, imp_exp[i]);
      chk("impulse_valid", enc_valid_o, 1);
    end
    drive(0, 0, 1);
    chk("impulse_hold_valid", enc_valid_o, 0);
    chk("impulse_hold_sym", enc_d_o, 2'b00);

    do_reset(1); valid_seen = 0;
    run_stream(256, 100, 0, -1);
    chk("clean_valid_cnt", valid_seen, 240);
`ifdef VITERBI_ERR_CNT_EN
    chk("clean_err_cnt", dec_err_cnt_o, 0);
`endif

    do_reset(1); valid_seen = 0;
    run_stream(256, 100, 1, -1);
    chk("burst_valid_cnt", valid_seen, 240);
`ifdef VITERBI_ERR_CNT_EN
    chk("burst_err_cnt", dec_err_cnt_o, 32);
`endif

    do_reset(1); valid_seen = 0;
    run_stream(256, 50, 0, -1);
    chk("gap_valid_cnt", valid_seen, 240);

    do_reset(1);
    run_stream(256, 100, 0, 40);
    do_reset(1);
    valid_seen = 0; first_pending = 1;
    run_stream(256, 100, 0, -1);
    chk("rst_first_valid_enable", first_en, TD + 1);
    chk("rst_first_bit", first_bit, 1);
    chk("rst_valid_cnt", valid_seen, 240);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
